wb_dest_pipe: RTL and testbench
===============================

# wb_dest_pipe

Tracks the register write destination of every in-flight instruction from decode to writeback. Each cycle it takes the 2-bit destination-select code from the decode stage's destination decoder and the raw instruction word, resolves the 3-bit architectural destination, and carries it with its write-enable through EX, MEM and WB pipeline registers. It supplies the register file's write address and enable, and raises a RAW hazard stall when a decode-stage source register matches an in-flight destination.

## Interface
Parameters:
- none; the register file is fixed at 8 entries with 3-bit indices, and the instruction word is fixed at 16 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- id_valid  input  1  decode stage holds a real instruction.
- id_instr  input  16  decode-stage instruction word.
- id_regdst  input  2  destination select from the destination decoder.
- id_regwrite  input  1  instruction writes the register file.
- id_rs_used  input  1  instruction reads the register in instr[10:8].
- id_rt_used  input  1  instruction reads the register in instr[7:5].
- flush  input  1  kill the decode-stage instruction (taken branch/jump).
- freeze  input  1  global pipeline stall (memory busy); holds all stages.
- ex_dest, mem_dest, wb_dest  output  3 each  destination register per stage.
- ex_wen, mem_wen, wb_wen  output  1 each  stage holds a valid register write.
- hazard  output  1  decode must stall; combinational.

## Operation
- Destination resolution: id_regdst 00 -> instr[4:2]; 01 -> instr[7:5]; 10 -> instr[10:8]; 11 -> 3'd7 (link register).
- Each stage stores {wen, dest}. A bubble is wen=0, dest=3'd0.
- Stage wen = id_valid & id_regwrite at entry. Invalid or non-writing instructions enter as bubbles.
- R0 is an ordinary register. There is no zero-register special case, so matches on index 0 count.
- hazard = (id_valid & id_rs_used & matchRs) | (id_valid & id_rt_used & matchRt).
  - matchX is true when X equals ex_dest with ex_wen=1, or mem_dest with mem_wen=1.
  - The WB stage is added to the comparison only under the macro below.
- hazard ignores flush and freeze.
- Update rule on each rising edge with rst_n=1:
  - freeze=1: all three stages hold.
  - Otherwise, WB <= MEM and MEM <= EX.
  - EX <= bubble if flush | hazard | ~id_valid; otherwise EX <= resolved entry.
- Simultaneous flush and hazard: a bubble enters EX. The upstream stage owns refetch.
- freeze overrides flush: flush asserted only during freeze is lost. Upstream must hold flush until freeze drops.
- Reset (rst_n=0 at an edge): all stages become bubbles, so every output is 0 and hazard evaluates to 0. Reset wins over freeze and mid-operation state.

## Timing
- Latency from the decode-stage edge to WB is 3 cycles without freeze. The instruction sampled at edge N appears on ex_* after N, mem_* after N+1, and wb_* after N+2.
- Each freeze cycle adds exactly one cycle to every in-flight entry.
- hazard is valid in the same cycle as the id_* inputs. It is purely combinational from id_* and stage registers, with no path through flush or freeze.
- wb_dest and wb_wen are registered outputs, stable for the whole cycle, and drive the register file write port directly.

## Configuration
- WB_DEST_CMP_EN defined: the WB stage is included in the hazard compare. Use this with a register file lacking write-before-read bypass; worst-case stall is 3 cycles.
- WB_DEST_CMP_EN undefined: only EX and MEM are compared. The register file must forward its same-cycle write to reads; worst-case stall is 2 cycles.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 and id_regwrite=1 -> all *_wen and *_dest are 0 and hazard=0; after release, the first instruction reaches wb_* 3 edges later.
- Decode mapping: id_instr=16'h0A1C with id_regdst 00/01/10/11 -> wb_dest 7/0/2/7 with wb_wen=1, all 3 cycles after issue.
- RAW stall: issue a write to R3, then an instruction with id_rs_used=1 and instr[10:8]=3 -> hazard=1 for 2 cycles (3 with WB_DEST_CMP_EN), with bubbles inserted into EX. The dependent instruction enters EX on the cycle after hazard falls.
- Flush: flush=1 with a valid writing instruction in ID -> ex_wen=0 next cycle; the older entries still advance to mem/wb unchanged.
- Freeze: assert freeze for 4 cycles with EX/MEM/WB holding R1/R2/R3 -> outputs unchanged for all 4 cycles. A flush pulse during the freeze is ignored, and the pipeline advances on the first non-freeze edge.
- Hazard with id_rs_used=0 and id_rt_used=0 against matching in-flight destinations -> hazard=0.

Source files
------------

// File: rtl/wb_dest_pipe_if.sv
// Bundle of decode-stage inputs and per-stage destination outputs for wb_dest_pipe.
interface wb_dest_pipe_if;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [1:0]  id_regdst;
  logic        id_regwrite;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        flush;
  logic        freeze;
  logic [2:0]  ex_dest;
  logic [2:0]  mem_dest;
  logic [2:0]  wb_dest;
  logic        ex_wen;
  logic        mem_wen;
  logic        wb_wen;
  logic        hazard;

  modport master (
    output id_valid, id_instr, id_regdst, id_regwrite, id_rs_used, id_rt_used,
    output flush, freeze,
    input  ex_dest, mem_dest, wb_dest, ex_wen, mem_wen, wb_wen, hazard
  );

  modport slave (
    input  id_valid, id_instr, id_regdst, id_regwrite, id_rs_used, id_rt_used,
    input  flush, freeze,
    output ex_dest, mem_dest, wb_dest, ex_wen, mem_wen, wb_wen, hazard
  );
endinterface

// File: rtl/wb_dest_pipe.sv
// Carries the resolved write destination of each instruction through EX/MEM/WB and flags RAW stalls.
// Macro WB_DEST_CMP_EN adds the WB stage to the hazard compare (register file without write bypass).
module wb_dest_pipe (
  input  logic           clk,
  input  logic           rst_n,
  wb_dest_pipe_if.slave  bus
);

  logic [2:0] ex_dest_r, mem_dest_r, wb_dest_r;
  logic       ex_wen_r, mem_wen_r, wb_wen_r;
  logic [2:0] rs_s, rt_s;
  logic       match_rs_s, match_rt_s, hazard_s;
  logic [2:0] ex_dest_nxt_s;
  logic       ex_wen_nxt_s;

  function automatic logic [2:0] resolve_dest(input logic [1:0] regdst, input logic [15:0] instr);
    logic [2:0] d;
    case (regdst)
      2'b00:   d = instr[4:2];
      2'b01:   d = instr[7:5];
      2'b10:   d = instr[10:8];
      2'b11:   d = 3'd7;
      default: d = 3'd0;
    endcase
    return d;
  endfunction

  // RAW detection: compare decode sources against in-flight writing stages (R0 included).
  always_comb begin
    rs_s = bus.id_instr[10:8];
    rt_s = bus.id_instr[7:5];
`ifdef WB_DEST_CMP_EN
    match_rs_s = (ex_wen_r  && (ex_dest_r  == rs_s)) ||
                 (mem_wen_r && (mem_dest_r == rs_s)) ||
                 (wb_wen_r  && (wb_dest_r  == rs_s));
    match_rt_s = (ex_wen_r  && (ex_dest_r  == rt_s)) ||
                 (mem_wen_r && (mem_dest_r == rt_s)) ||
                 (wb_wen_r  && (wb_dest_r  == rt_s));
`else
    match_rs_s = (ex_wen_r  && (ex_dest_r  == rs_s)) ||
                 (mem_wen_r && (mem_dest_r == rs_s));
    match_rt_s = (ex_wen_r  && (ex_dest_r  == rt_s)) ||
                 (mem_wen_r && (mem_dest_r == rt_s));
`endif
    hazard_s = bus.id_valid && ((bus.id_rs_used && match_rs_s) || (bus.id_rt_used && match_rt_s));
  end

  // EX entry: anything that will not write the register file enters as an all-zero bubble.
  always_comb begin
    if (bus.flush || hazard_s || !bus.id_valid || !bus.id_regwrite) begin
      ex_wen_nxt_s  = 1'b0;
      ex_dest_nxt_s = 3'd0;
    end else begin
      ex_wen_nxt_s  = 1'b1;
      ex_dest_nxt_s = resolve_dest(bus.id_regdst, bus.id_instr);
    end
  end

  // Stage registers: reset beats freeze, freeze holds everything (and drops any flush).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_wen_r   <= 1'b0;
      ex_dest_r  <= 3'd0;
      mem_wen_r  <= 1'b0;
      mem_dest_r <= 3'd0;
      wb_wen_r   <= 1'b0;
      wb_dest_r  <= 3'd0;
    end else if (bus.freeze) begin
      ex_wen_r   <= ex_wen_r;
      ex_dest_r  <= ex_dest_r;
      mem_wen_r  <= mem_wen_r;
      mem_dest_r <= mem_dest_r;
      wb_wen_r   <= wb_wen_r;
      wb_dest_r  <= wb_dest_r;
    end else begin
      ex_wen_r   <= ex_wen_nxt_s;
      ex_dest_r  <= ex_dest_nxt_s;
      mem_wen_r  <= ex_wen_r;
      mem_dest_r <= ex_dest_r;
      wb_wen_r   <= mem_wen_r;
      wb_dest_r  <= mem_dest_r;
    end
  end

  assign bus.ex_dest  = ex_dest_r;
  assign bus.ex_wen   = ex_wen_r;
  assign bus.mem_dest = mem_dest_r;
  assign bus.mem_wen  = mem_wen_r;
  assign bus.wb_dest  = wb_dest_r;
  assign bus.wb_wen   = wb_wen_r;
  assign bus.hazard   = hazard_s;

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Self-checking bench for wb_dest_pipe: decode table, hand-written corner sequences, random vs model.
module tb_wb_dest_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_dest_pipe_if bus ();

  wb_dest_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef WB_DEST_CMP_EN
  localparam int NCMP = 3;
`else
  localparam int NCMP = 2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit       wen;
    bit [2:0] dest;
  } entry_t;

  // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  entry_t pipe [3];

  typedef struct {
    bit [1:0]  regdst;
    bit [15:0] instr;
    bit        regwrite;
    bit [2:0]  exp_dest;
    bit        exp_wen;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [2:0] ref_dest(input bit [1:0] sel, input bit [15:0] instr);
    bit [15:0] t;
    if (sel == 2'd3) return 3'd7;
    t = instr >> (2 + 3 * int'(sel));
    return t[2:0];
  endfunction

  function automatic bit ref_hazard(input bit valid, input bit rs_used, input bit rt_used,
                                    input bit [15:0] instr);
    bit [2:0] rs;
    bit [2:0] rt;
    rs = instr[10:8];
    rt = instr[7:5];
    for (int i = 0; i < NCMP; i++) begin
      if (pipe[i].wen && ((rs_used && pipe[i].dest == rs) || (rt_used && pipe[i].dest == rt)))
        return valid;
    end
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit h;
    h = ref_hazard(bus.id_valid, bus.id_rs_used, bus.id_rt_used, bus.id_instr);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 3'd0};
    end else if (!bus.freeze) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (bus.id_valid && bus.id_regwrite && !bus.flush && !h)
        pipe[0] = '{1'b1, ref_dest(bus.id_regdst, bus.id_instr)};
      else
        pipe[0] = '{1'b0, 3'd0};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit valid, input bit [15:0] instr, input bit [1:0] regdst,
                       input bit regwrite, input bit rs, input bit rt, input bit fl, input bit fr);
    bus.id_valid    = valid;
    bus.id_instr    = instr;
    bus.id_regdst   = regdst;
    bus.id_regwrite = regwrite;
    bus.id_rs_used  = rs;
    bus.id_rt_used  = rt;
    bus.flush       = fl;
    bus.freeze      = fr;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_stages(input string tag, input bit [2:0] ed, input bit ew,
                              input bit [2:0] md, input bit mw, input bit [2:0] wd, input bit ww);
    check({tag, "_ex_dest"},  bus.ex_dest,  ed);
    check({tag, "_ex_wen"},   bus.ex_wen,   ew);
    check({tag, "_mem_dest"}, bus.mem_dest, md);
    check({tag, "_mem_wen"},  bus.mem_wen,  mw);
    check({tag, "_wb_dest"},  bus.wb_dest,  wd);
    check({tag, "_wb_wen"},   bus.wb_wen,   ww);
  endtask

  initial begin
    int stall;
    bit exp_h;

    vecs[0] = '{2'b00, 16'h0A1C, 1'b1, 3'd7, 1'b1};
    vecs[1] = '{2'b01, 16'h0A1C, 1'b1, 3'd0, 1'b1};
    vecs[2] = '{2'b10, 16'h0A1C, 1'b1, 3'd2, 1'b1};
    vecs[3] = '{2'b11, 16'h0A1C, 1'b1, 3'd7, 1'b1};
    vecs[4] = '{2'b10, 16'h0A1C, 1'b0, 3'd0, 1'b0};

    // Reset held with a valid writing instruction present.
    rst_n = 1'b0;
    drive(1'b1, 16'h0A1C, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check_stages("reset", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    check("reset_hazard", bus.hazard, 1'b0);

    // First instruction after release reaches WB three edges later.
    rst_n = 1'b1;
    drive(1'b1, 16'h0A1C, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check("first_ex_dest", bus.ex_dest, 3'd7);
    check("first_ex_wen", bus.ex_wen, 1'b1);
    tick();
    check("first_wb_early", bus.wb_wen, 1'b0);
    tick();
    check("first_wb_dest", bus.wb_dest, 3'd7);
    check("first_wb_wen", bus.wb_wen, 1'b1);

    // Decode mapping table.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].regdst, vecs[i].regwrite, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      tick();
      check($sformatf("decode%0d_wb_dest", i), bus.wb_dest, vecs[i].exp_dest);
      check($sformatf("decode%0d_wb_wen", i), bus.wb_wen, vecs[i].exp_wen);
    end

    // RAW stall: write R3, then read R3 through rs.
    drive(1'b1, 16'h000C, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0300, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (!bus.hazard) break;
      stall++;
      tick();
      check("raw_bubble_ex_wen", bus.ex_wen, 1'b0);
    end
    check("raw_stall_cycles", stall, NCMP);
    tick();
    idle();
    check("raw_dep_ex_wen", bus.ex_wen, 1'b1);
    check("raw_dep_ex_dest", bus.ex_dest, 3'd0);
    tick();
    tick();
    tick();

    // Flush kills the decode instruction; older entries advance.
    drive(1'b1, 16'h0004, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0008, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    check("flush_ex_wen", bus.ex_wen, 1'b0);
    check("flush_mem_dest", bus.mem_dest, 3'd1);
    check("flush_mem_wen", bus.mem_wen, 1'b1);
    tick();
    check("flush_wb_dest", bus.wb_dest, 3'd1);
    check("flush_wb_wen", bus.wb_wen, 1'b1);
    check("flush_mem_wen2", bus.mem_wen, 1'b0);

    // Freeze with EX/MEM/WB = R1/R2/R3, flush pulse inside the freeze.
    drive(1'b1, 16'h000C, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0008, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0004, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_stages("prefreeze", 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'h0010, 2'd0, 1'b1, 1'b0, 1'b0, k == 1, 1'b1);
      tick();
      check_stages($sformatf("freeze%0d", k), 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1);
    end
    drive(1'b1, 16'h0014, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_stages("unfreeze", 3'd5, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1);

    // Hazard gating by source-used flags; EX=R5, MEM=R1, WB=R2.
    drive(1'b1, 16'h0120, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("nouse_hazard", bus.hazard, 1'b0);
    drive(1'b1, 16'h0120, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("rs_mem_hazard", bus.hazard, 1'b1);
    drive(1'b1, 16'h0120, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 check("rt_mem_hazard", bus.hazard, 1'b1);
    drive(1'b1, 16'h0200, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("rs_wb_hazard", bus.hazard, NCMP == 3);
    drive(1'b0, 16'h0120, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 check("invalid_hazard", bus.hazard, 1'b0);
    idle();

    // Randomized run against the reference model.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      #1;
      exp_h = ref_hazard(bus.id_valid, bus.id_rs_used, bus.id_rt_used, bus.id_instr);
      check("rand_hazard", bus.hazard, exp_h);
      tick();
      check_stages("rand", pipe[0].dest, pipe[0].wen, pipe[1].dest, pipe[1].wen,
                   pipe[2].dest, pipe[2].wen);
    end
    rst_n = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
